// File: rtl/spu_draw_sequencer_if.sv
// Host-side bundle of the draw sequencer: frame control, per-stage
// start/done handshake, and status pulses.
interface spu_draw_sequencer_if #(
  parameter int NUM_STAGES = 3,
  parameter int TO_W       = 16,
  parameter int FC_W       = 8
);
  logic                  frame_tick;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_done;
  logic                  abort;
  logic [TO_W-1:0]       timeout_limit;
  logic [NUM_STAGES-1:0] stage_start;
  logic                  busy;
  logic [2:0]            cur_stage;
  logic                  frame_done;
  logic                  frame_overrun;
  logic                  timeout_err;
  logic [FC_W-1:0]       frame_count;

  modport master (
    output frame_tick, stage_en, stage_done, abort, timeout_limit,
    input  stage_start, busy, cur_stage, frame_done, frame_overrun,
           timeout_err, frame_count
  );

  modport slave (
    input  frame_tick, stage_en, stage_done, abort, timeout_limit,
    output stage_start, busy, cur_stage, frame_done, frame_overrun,
           timeout_err, frame_count
  );
endinterface

// File: rtl/spu_draw_sequencer.sv
// Walks the enabled draw stages of a frame in ascending order, one start
// pulse per stage, advancing on that stage's done or on a per-stage timeout.
module spu_draw_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int TO_W       = 16,
  parameter int FC_W       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  spu_draw_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t                state, state_nxt;
  logic [2:0]            idx, idx_nxt;
  logic [NUM_STAGES-1:0] mask, mask_nxt;
  logic [TO_W-1:0]       to_cnt, to_cnt_nxt;
  logic [FC_W-1:0]       fc_q, fc_nxt;
  logic                  busy_q, busy_nxt;
  logic [NUM_STAGES-1:0] start_q, start_nxt;
  logic                  done_q, done_nxt;
  logic                  ovr_q, ovr_nxt;
  logic                  done_sel, to_hit;
  logic [3:0]            nb, first;

  // {found, index} of the lowest set bit of m strictly above position 'from'
  function automatic logic [3:0] next_bit(input logic [NUM_STAGES-1:0] m,
                                          input int from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_STAGES - 1; i >= 0; i--)
      if (m[i] && i > from) r = {1'b1, 3'(i)};
    return r;
  endfunction

  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (3'(i) == idx) done_sel = bus.stage_done[i];
  end

  // Done beats timeout; an aborted frame reports nothing.
  assign to_hit = (state == WAIT) && (bus.timeout_limit != '0) &&
                  (to_cnt == bus.timeout_limit - TO_W'(1)) &&
                  !done_sel && !bus.abort;

  assign nb    = next_bit(mask, int'(idx));
  assign first = next_bit(bus.stage_en, -1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      mask    <= '0;
      to_cnt  <= '0;
      fc_q    <= '0;
      busy_q  <= 1'b0;
      start_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      mask    <= mask_nxt;
      to_cnt  <= to_cnt_nxt;
      fc_q    <= fc_nxt;
      busy_q  <= busy_nxt;
      start_q <= start_nxt;
      done_q  <= done_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    mask_nxt   = mask;
    to_cnt_nxt = to_cnt;
    fc_nxt     = fc_q;
    busy_nxt   = busy_q;
    start_nxt  = '0;
    done_nxt   = 1'b0;
    ovr_nxt    = bus.frame_tick && (state != IDLE);

    case (state)
      IDLE: begin
        if (bus.frame_tick && !bus.abort) begin
          mask_nxt = bus.stage_en;
          busy_nxt = 1'b1;
          if (first[3]) begin
            idx_nxt   = first[2:0];
            state_nxt = LAUNCH;
          end else begin
            idx_nxt   = '0;
            state_nxt = FINISH;
          end
        end
      end
      LAUNCH: begin
        to_cnt_nxt = '0;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (to_cnt != '1) to_cnt_nxt = to_cnt + TO_W'(1);
        if (done_sel || to_hit) begin
          if (nb[3]) begin
            idx_nxt   = nb[2:0];
            state_nxt = LAUNCH;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        done_nxt  = 1'b1;
        fc_nxt    = fc_q + FC_W'(1);
        busy_nxt  = 1'b0;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.abort && state != IDLE) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      fc_nxt    = fc_q;
    end

    // Start is registered on entry to LAUNCH so it lands one cycle after the trigger.
    if (state_nxt == LAUNCH)
      for (int i = 0; i < NUM_STAGES; i++) start_nxt[i] = (3'(i) == idx_nxt);
  end

  assign bus.stage_start   = start_q;
  assign bus.busy          = busy_q;
  assign bus.cur_stage     = (state == IDLE) ? 3'd0 : idx;
  assign bus.frame_done    = done_q;
  assign bus.frame_overrun = ovr_q;
  assign bus.timeout_err   = to_hit;
  assign bus.frame_count   = fc_q;

endmodule

// File: tb/tb_spu_draw_sequencer.sv
// Table of frame scenarios with a start/timeout/frame_done scoreboard, plus
// hand sequences for overrun, abort and reset corners.
module tb_spu_draw_sequencer;

  localparam int NS = 3;
  localparam int TW = 16;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spu_draw_sequencer_if #(.NUM_STAGES(NS), .TO_W(TW), .FC_W(FW)) bus ();

  spu_draw_sequencer #(.NUM_STAGES(NS), .TO_W(TW), .FC_W(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  en;
    int          dly;
    logic [15:0] lim;
    logic [2:0]  hang;
    int          n_st;
    int          st_stage [3];
    int          st_cyc [3];
    int          to_cyc;
    int          fd_cyc;
  } vec_t;

  vec_t tbl [8];
  int   exp_st_stage [$];
  int   exp_st_cyc [$];
  int   exp_to [$];
  int   exp_fd [$];
  int   checks = 0;
  int   fails = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [2:0] en, input int dly,
                         input logic [15:0] lim, input logic [2:0] hang, input int n,
                         input int s0, input int c0, input int s1, input int c1,
                         input int s2, input int c2, input int to, input int fd);
    tbl[i].en = en; tbl[i].dly = dly; tbl[i].lim = lim; tbl[i].hang = hang;
    tbl[i].n_st = n;
    tbl[i].st_stage[0] = s0; tbl[i].st_cyc[0] = c0;
    tbl[i].st_stage[1] = s1; tbl[i].st_cyc[1] = c1;
    tbl[i].st_stage[2] = s2; tbl[i].st_cyc[2] = c2;
    tbl[i].to_cyc = to; tbl[i].fd_cyc = fd;
  endtask

  // Entered mid-cycle; the tick is driven in this cycle (cycle 0).
  task automatic run_vec(input vec_t v);
    int cyc, ov, multi;
    int done_at [3];
    bit fd_seen;
    for (int i = 0; i < v.n_st; i++) begin
      exp_st_stage.push_back(v.st_stage[i]);
      exp_st_cyc.push_back(v.st_cyc[i]);
    end
    if (v.to_cyc > 0) exp_to.push_back(v.to_cyc);
    exp_fd.push_back(v.fd_cyc);
    exp_cnt = (exp_cnt + 1) % (1 << FW);
    for (int i = 0; i < 3; i++) done_at[i] = -1;
    cyc = 0; ov = 0; multi = 0; fd_seen = 1'b0;
    bus.stage_en = v.en; bus.timeout_limit = v.lim; bus.stage_done = '0;
    bus.abort = 1'b0; bus.frame_tick = 1'b1;
    while (cyc < 40 && !fd_seen) begin
      step();
      cyc++;
      bus.frame_tick = 1'b0;
      bus.stage_en = ~v.en;
      for (int i = 0; i < 3; i++) bus.stage_done[i] = (done_at[i] == cyc);
      #1;
      if ($countones(bus.stage_start) > 1) multi++;
      for (int i = 0; i < 3; i++) if (bus.stage_start[i]) begin
        if (exp_st_cyc.size() == 0) chk("start_extra", 1, 0);
        else begin
          chk("start_stage", i, exp_st_stage.pop_front());
          chk("start_cyc", cyc, exp_st_cyc.pop_front());
        end
        chk("cur_stage", bus.cur_stage, i);
        if (!v.hang[i]) done_at[i] = cyc + v.dly;
      end
      if (bus.timeout_err) begin
        if (exp_to.size() == 0) chk("timeout_extra", 1, 0);
        else chk("timeout_cyc", cyc, exp_to.pop_front());
      end
      if (bus.frame_overrun) ov++;
      if (bus.frame_done) begin
        fd_seen = 1'b1;
        chk("fd_cyc", cyc, exp_fd.pop_front());
        chk("frame_count", bus.frame_count, exp_cnt);
        chk("fd_busy", bus.busy, 0);
      end
    end
    chk("fd_seen", fd_seen, 1);
    chk("start_left", exp_st_cyc.size(), 0);
    chk("timeout_left", exp_to.size(), 0);
    chk("overrun_none", ov, 0);
    chk("onehot_start", multi, 0);
    exp_st_stage.delete(); exp_st_cyc.delete(); exp_to.delete(); exp_fd.delete();
    bus.stage_done = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    //          en      dly lim    hang    n  s0 c0 s1 c1 s2 c2 to fd
    set_vec(0, 3'b111, 2, 16'd0, 3'b000, 3, 0, 1, 1, 4, 2, 7, 0, 11);
    set_vec(1, 3'b101, 2, 16'd0, 3'b000, 2, 0, 1, 2, 4, 0, 0, 0, 8);
    set_vec(2, 3'b000, 2, 16'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    set_vec(3, 3'b111, 2, 16'd4, 3'b010, 3, 0, 1, 1, 4, 2, 9, 8, 13);
    set_vec(4, 3'b001, 2, 16'd2, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0, 5);
    set_vec(5, 3'b001, 2, 16'd1, 3'b001, 1, 0, 1, 0, 0, 0, 0, 2, 4);
    set_vec(6, 3'b011, 1, 16'd0, 3'b000, 2, 0, 1, 1, 3, 0, 0, 0, 6);
    set_vec(7, 3'b100, 2, 16'd0, 3'b000, 1, 2, 1, 0, 0, 0, 0, 0, 5);

    bus.frame_tick = 1'b0; bus.stage_en = '0; bus.stage_done = '0;
    bus.abort = 1'b0; bus.timeout_limit = '0;
    repeat (3) step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.stage_start, 0);
    chk("rst_fd", bus.frame_done, 0);
    chk("rst_count", bus.frame_count, 0);
    chk("rst_cur", bus.cur_stage, 0);
    chk("rst_ovr", bus.frame_overrun, 0);
    chk("rst_to", bus.timeout_err, 0);

    // Release mid-cycle so the very first edge samples the tick.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    run_vec(tbl[0]);

    // Tick while waiting: overrun pulse, frame unaffected; then abort it.
    bus.stage_en = 3'b001; bus.timeout_limit = '0; bus.frame_tick = 1'b1;
    step(); bus.frame_tick = 1'b0; #1;
    chk("ovr_first_start", bus.stage_start, 3'b001);
    step(); step(); bus.frame_tick = 1'b1;
    step(); bus.frame_tick = 1'b0; #1;
    chk("overrun", bus.frame_overrun, 1);
    chk("ovr_busy", bus.busy, 1);
    chk("ovr_no_start", bus.stage_start, 0);
    step(); bus.abort = 1'b1; #1;
    chk("overrun_pulse", bus.frame_overrun, 0);
    chk("abort_busy_pre", bus.busy, 1);
    step(); bus.abort = 1'b0; #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_cur", bus.cur_stage, 0);
    bad = 0;
    repeat (4) begin
      step();
      if (bus.frame_done || bus.stage_start != '0) bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_count", bus.frame_count, exp_cnt);

    // Abort in FINISH drops the frame_done pulse and the count.
    bus.stage_en = 3'b000; bus.frame_tick = 1'b1;
    step(); bus.frame_tick = 1'b0; bus.abort = 1'b1; #1;
    chk("fin_busy", bus.busy, 1);
    step(); bus.abort = 1'b0; #1;
    chk("fin_abort_fd", bus.frame_done, 0);
    chk("fin_abort_cnt", bus.frame_count, exp_cnt);
    chk("fin_abort_busy", bus.busy, 0);

    // Abort beats tick in IDLE; next tick works; abort in LAUNCH.
    bus.stage_en = 3'b001; bus.abort = 1'b1; bus.frame_tick = 1'b1;
    step(); bus.abort = 1'b0; bus.frame_tick = 1'b0; #1;
    chk("idle_abort_busy", bus.busy, 0);
    chk("idle_abort_start", bus.stage_start, 0);
    bus.frame_tick = 1'b1;
    step(); bus.frame_tick = 1'b0; #1;
    chk("idle_abort_recover", bus.stage_start, 3'b001);
    bus.abort = 1'b1;
    step(); bus.abort = 1'b0; #1;
    chk("launch_abort_busy", bus.busy, 0);
    run_vec(tbl[6]);

    // Reset mid-frame abandons it with no frame_done.
    bus.stage_en = 3'b111; bus.frame_tick = 1'b1;
    step(); bus.frame_tick = 1'b0;
    step(); step();
    rst_n = 1'b0; #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_count", bus.frame_count, 0);
    chk("mid_rst_start", bus.stage_start, 0);
    step(); rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      step();
      if (bus.frame_done || bus.busy) bad++;
    end
    chk("mid_rst_quiet", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
